// File: rtl/vm_pkg.sv
// vm_pkg: shared event codes, colour masks, blink counts and LED driver state encoding.
package vm_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ON = 2'd1, ST_OFF = 2'd2} state_e;
    localparam logic [2:0] EV_NONE     = 3'd0;
    localparam logic [2:0] EV_DISPENSE = 3'd1;
    localparam logic [2:0] EV_CHANGE   = 3'd2;
    localparam logic [2:0] EV_REFUND   = 3'd3;
    localparam logic [2:0] EV_ERROR    = 3'd4;
    localparam logic [2:0] COL_R = 3'b100;
    localparam logic [2:0] COL_G = 3'b010;
    localparam logic [2:0] COL_B = 3'b001;
    localparam logic [2:0] N_DISPENSE = 3'd3;
    localparam logic [2:0] N_CHANGE   = 3'd2;
    localparam logic [2:0] N_REFUND   = 3'd2;
    localparam logic [2:0] N_ERROR    = 3'd4;
    // A zero blink count marks NONE and reserved codes as unplayable.
    function automatic logic [2:0] ev_blinks(input logic [2:0] c);
        return c == EV_DISPENSE ? N_DISPENSE : c == EV_CHANGE ? N_CHANGE :
               c == EV_REFUND ? N_REFUND : c == EV_ERROR ? N_ERROR : 3'd0;
    endfunction
    function automatic logic [2:0] ev_mask(input logic [2:0] c);
        return c == EV_DISPENSE ? COL_G : c == EV_CHANGE ? COL_B :
               c == EV_REFUND ? (COL_R | COL_G) : c == EV_ERROR ? COL_R : 3'b000;
    endfunction
endpackage

// File: rtl/vend_status_led_driver_if.sv
// vend_status_led_driver_if: valid/ready status event channel from the vending core.
interface vend_status_led_driver_if;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic       ev_ready;
    modport master (output ev_valid, ev_code, input ev_ready);
    modport slave  (input ev_valid, ev_code, output ev_ready);
endinterface

// File: rtl/vend_status_led_driver_rgb_pwm.sv
// rgb_pwm: free-running PWM counter; pwm_on is the compare for the count the next cycle holds,
// so LED flops loaded from it line up with the counter value.
module rgb_pwm #(
    parameter int PWM_BITS = 8,
    parameter int DUTY     = 64
) (
    input  logic clk,
    input  logic rst,
    output logic pwm_on
);
    localparam logic [PWM_BITS-1:0] DUTY_V = PWM_BITS'(DUTY);
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d  = cnt_q + PWM_BITS'(1);
        pwm_on = cnt_d < DUTY_V;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/vend_status_led_driver.sv
// vend_status_led_driver: plays accepted status events as PWM-dimmed RGB blink patterns,
// with a one-deep pending slot and ERROR preemption.
module vend_status_led_driver
    import vm_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int DUTY       = 64,
    parameter int BLINK_HALF = 12500000
) (
    input  logic                      clk,
    input  logic                      rst,
    vend_status_led_driver_if.slave   ev,
    output logic                      busy,
    output logic                      led_r,
    output logic                      led_g,
    output logic                      led_b
);
    localparam int PW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(BLINK_HALF - 1);
    state_e          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [2:0]      blink_q, blink_d, code_q, code_d, pend_code_q, pend_code_d;
    logic [2:0]      led_q, led_d, start_code;
    logic            pend_valid_q, pend_valid_d, busy_q, busy_d;
    logic            pwm_on, take, last_phase, last_blink, pat_end, preempt, start, store;
    rgb_pwm #(.PWM_BITS(PWM_BITS), .DUTY(DUTY)) u_pwm (.clk(clk), .rst(rst), .pwm_on(pwm_on));
    assign ev.ev_ready = !pend_valid_q;
    always_comb begin
        take       = ev.ev_valid && !pend_valid_q && ev_blinks(ev.ev_code) != 3'd0;
        last_phase = phase_q == PH_LAST;
        last_blink = blink_q == ev_blinks(code_q) - 3'd1;
        pat_end    = state_q == ST_OFF && last_phase && last_blink;
        preempt    = take && state_q != ST_IDLE && ev.ev_code == EV_ERROR && code_q != EV_ERROR;
        // take implies an empty slot, so the pending code only starts on a natural pattern end
        start      = (take && (state_q == ST_IDLE || pat_end || preempt)) || (pat_end && pend_valid_q);
        store      = take && !start;
        start_code = pend_valid_q ? pend_code_q : ev.ev_code;
        state_d    = state_q;
        if (last_phase && state_q == ST_ON) state_d = ST_OFF;
        if (last_phase && state_q == ST_OFF) begin
            if (last_blink) state_d = ST_IDLE;
            else            state_d = ST_ON;
        end
        phase_d      = (state_q == ST_IDLE || last_phase) ? '0 : phase_q + PW'(1);
        blink_d      = (state_q == ST_OFF && last_phase) ? blink_q + 3'd1 : blink_q;
        code_d       = code_q;
        pend_valid_d = store || (pend_valid_q && !pat_end);
        pend_code_d  = store ? ev.ev_code : pend_code_q;
        if (start) begin
            state_d = ST_ON;
            phase_d = '0;
            blink_d = '0;
            code_d  = start_code;
        end
        busy_d = state_d != ST_IDLE;
        led_d  = (state_d == ST_ON && pwm_on) ? ev_mask(code_d) : 3'b000;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            blink_q      <= '0;
            code_q       <= EV_NONE;
            pend_valid_q <= 1'b0;
            pend_code_q  <= EV_NONE;
            busy_q       <= 1'b0;
            led_q        <= 3'b000;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            blink_q      <= blink_d;
            code_q       <= code_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
            busy_q       <= busy_d;
            led_q        <= led_d;
        end
    end
    assign busy  = busy_q;
    assign led_r = led_q[2];
    assign led_g = led_q[1];
    assign led_b = led_q[0];
endmodule
